// File: rtl/vga_hex_overlay.sv
// Hex-dump overlay pixel stage: draws NUM_WORDS 32-bit words as rows of 8 hex
// digits with a fixed 3-clock latency. Optional row highlight: VGA_HEX_HILITE_EN.
module vga_hex_overlay #(
  parameter int          NUM_WORDS = 16,
  parameter int          X0        = 16,
  parameter int          Y0        = 16,
  parameter logic [23:0] FG_RGB    = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB    = 24'h000080,
  localparam int         IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             video_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
`ifdef VGA_HEX_HILITE_EN
  input  logic [IDX_W-1:0] hilite_idx,
`endif
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      word_data,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             hsync,
  output logic             vsync
);

  // Block bounds widened to 11 bits so X0+64 / Y0+16*NUM_WORDS never wrap.
  localparam logic [10:0] X_LO  = 11'(X0);
  localparam logic [10:0] X_HI  = 11'(X0 + 64);
  localparam logic [10:0] Y_LO  = 11'(Y0);
  localparam logic [10:0] Y_HI  = 11'(Y0 + 16 * NUM_WORDS);
  localparam logic [9:0]  X_OFF = 10'(X0);
  localparam logic [9:0]  Y_OFF = 10'(Y0);

  // Glyph rows 1..13, first byte is row 1; rows 0, 14, 15 are always blank.
  localparam logic [103:0] FONT [16] = '{
    104'h00_3C_66_66_6E_76_66_66_66_3C_00_00_00,  // 0
    104'h00_18_38_18_18_18_18_18_18_7E_00_00_00,  // 1
    104'h00_3C_66_06_0C_18_30_60_66_7E_00_00_00,  // 2
    104'h00_3C_66_06_1C_06_06_06_66_3C_00_00_00,  // 3
    104'h00_0C_1C_3C_6C_CC_FE_0C_0C_1E_00_00_00,  // 4
    104'h00_7E_60_60_7C_06_06_06_66_3C_00_00_00,  // 5
    104'h00_1C_30_60_7C_66_66_66_66_3C_00_00_00,  // 6
    104'h00_7E_66_06_0C_18_18_18_18_18_00_00_00,  // 7
    104'h00_3C_66_66_3C_66_66_66_66_3C_00_00_00,  // 8
    104'h00_3C_66_66_66_3E_06_06_0C_38_00_00_00,  // 9
    104'h00_18_3C_66_66_7E_66_66_66_66_00_00_00,  // A
    104'h00_7C_66_66_7C_66_66_66_66_7C_00_00_00,  // B
    104'h00_3C_66_60_60_60_60_60_66_3C_00_00_00,  // C
    104'h00_78_6C_66_66_66_66_66_6C_78_00_00_00,  // D
    104'h00_7E_60_60_7C_60_60_60_60_7E_00_00_00,  // E
    104'h00_7E_60_60_7C_60_60_60_60_60_00_00_00   // F
  };

  function automatic logic [7:0] font_row(input logic [3:0] nib, input logic [3:0] g);
    logic [103:0] shifted;
    shifted  = FONT[nib] << {g - 4'd1, 3'b000};
    font_row = 8'h00;
    if (g != 4'd0 && g <= 4'd13) font_row = shifted[103:96];
  endfunction

  // Stage 1: position decode
  logic             in_reg_d, in_reg_q;
  logic [2:0]       digit_d, digit_q;
  logic [2:0]       col_d, col_q;
  logic [3:0]       grow_d, grow_q;
  logic [IDX_W-1:0] rd_idx_d, rd_idx_q;
  logic             hil_d, hil_q;
  logic             von1_d, von1_q, hs1_d, hs1_q, vs1_d, vs1_q;
  // Stage 2: glyph lookup
  logic [7:0]       font_bits_d, font_bits_q;
  logic [2:0]       col2_d, col2_q;
  logic             in2_d, in2_q, hil2_d, hil2_q;
  logic             von2_d, von2_q, hs2_d, hs2_q, vs2_d, vs2_q;
  // Stage 3: colour out
  logic [23:0]      rgb_d, rgb_q;
  logic             hsync_d, hsync_q, vsync_d, vsync_q;

  logic [5:0]       rx;
  logic [IDX_W+3:0] ry;
  logic [IDX_W-1:0] row;
  logic [3:0]       nib;
  logic             pix;

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    rx  = 6'(x - X_OFF);
    ry  = (IDX_W + 4)'(y - Y_OFF);
    row = ry[IDX_W+3:4];

    // Range test on the raw coordinates; rx/ry are only meaningful inside.
    in_reg_d = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
               ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    digit_d  = rx[5:3];
    col_d    = rx[2:0];
    grow_d   = ry[3:0];
    rd_idx_d = in_reg_d ? row : rd_idx_q;
`ifdef VGA_HEX_HILITE_EN
    hil_d    = (row == hilite_idx);
`else
    hil_d    = 1'b0;
`endif
    von1_d   = video_on;
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;

    nib         = word_data[5'd28 - {digit_q, 2'b00} +: 4];
    font_bits_d = font_row(nib, grow_q);
    col2_d      = col_q;
    in2_d       = in_reg_q;
    hil2_d      = hil_q;
    von2_d      = von1_q;
    hs2_d       = hs1_q;
    vs2_d       = vs1_q;

    pix   = font_bits_q[3'd7 - col2_q];
    rgb_d = 24'h000000;
    if (von2_q && in2_q) rgb_d = (pix ^ hil2_q) ? FG_RGB : BG_RGB;
    hsync_d = hs2_q;
    vsync_d = vs2_q;
  end

  // NOTE: state flops use non-blocking assignments so all stages advance on the same edge.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      in_reg_q    <= 1'b0;
      digit_q     <= '0;
      col_q       <= '0;
      grow_q      <= '0;
      rd_idx_q    <= '0;
      hil_q       <= 1'b0;
      von1_q      <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      font_bits_q <= '0;
      col2_q      <= '0;
      in2_q       <= 1'b0;
      hil2_q      <= 1'b0;
      von2_q      <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      in_reg_q    <= in_reg_d;
      digit_q     <= digit_d;
      col_q       <= col_d;
      grow_q      <= grow_d;
      rd_idx_q    <= rd_idx_d;
      hil_q       <= hil_d;
      von1_q      <= von1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      font_bits_q <= font_bits_d;
      col2_q      <= col2_d;
      in2_q       <= in2_d;
      hil2_q      <= hil2_d;
      von2_q      <= von2_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign rd_idx = rd_idx_q;
  assign vga_r  = rgb_q[23:16];
  assign vga_g  = rgb_q[15:8];
  assign vga_b  = rgb_q[7:0];
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;

endmodule
